// File: rtl/people_top_control.sv
// people_top_control: player sprite position controller with tick-paced movement, clamping and IDLE/PLAY/DEAD/WIN control.
module people_top_control #(
    parameter int TICK_CYCLES  = 1_000_000,
    parameter int ACTIVE_STAGE = 5,
    parameter int START_UP     = 335,
    parameter int START_LEFT   = 160,
    parameter int MIN_UP       = 40,
    parameter int MAX_UP       = 400,
    parameter int MIN_LEFT     = 160,
    parameter int MAX_LEFT     = 440,
    parameter int GOAL_LEFT    = 430
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] stage_state,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       fail,
    output logic [9:0] people_up,
    output logic [9:0] people_left,
    output logic [1:0] people_dir,
    output logic       win,
    output logic [1:0] state
);
    localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DEAD, WIN} state_t;

    state_t st, st_n;
    logic [CW-1:0] cnt;
    logic tick, active, go_u, go_d, go_l, go_r, mv;
    logic [9:0] up_n, left_n;
    logic [1:0] dir_n;

    assign active = stage_state == 3'(ACTIVE_STAGE);
    assign state = st;
    assign win = st == WIN;

    always_ff @(posedge clk)
        st <= rst ? IDLE : st_n;

    always_comb begin
        st_n = st;
        case (st)
            IDLE: st_n = active && !fail ? PLAY : IDLE;
            PLAY: st_n = !active ? IDLE : fail ? DEAD : people_left >= 10'(GOAL_LEFT) ? WIN : PLAY;
            default: st_n = active ? st : IDLE;
        endcase
    end

    // Opposing keys cancel, so the priority chain only ever sees one key per axis.
    assign go_u = key_up & ~key_down;
    assign go_d = key_down & ~key_up;
    assign go_l = key_left & ~key_right;
    assign go_r = key_right & ~key_left;
    assign mv = go_u | go_d | go_l | go_r;
    assign dir_n = go_u ? 2'd2 : go_d ? 2'd3 : go_l ? 2'd1 : 2'd0;
    assign up_n = go_u ? (people_up > 10'(MIN_UP) ? people_up - 10'd1 : people_up)
                : go_d ? (people_up < 10'(MAX_UP) ? people_up + 10'd1 : people_up)
                : people_up;
    assign left_n = (go_u | go_d) ? people_left
                  : go_l ? (people_left > 10'(MIN_LEFT) ? people_left - 10'd1 : people_left)
                  : go_r ? (people_left < 10'(MAX_LEFT) ? people_left + 10'd1 : people_left)
                  : people_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tick <= 1'b0;
            people_up <= 10'(START_UP);
            people_left <= 10'(START_LEFT);
            people_dir <= 2'd0;
        end else begin
            tick <= st == PLAY && cnt == LAST;
            cnt <= (st != PLAY || cnt == LAST) ? '0 : cnt + CW'(1);
            if (st == IDLE) begin
                people_up <= 10'(START_UP);
                people_left <= 10'(START_LEFT);
                people_dir <= 2'd0;
            end else if (st == PLAY && tick && mv) begin
                people_up <= up_n;
                people_left <= left_n;
                people_dir <= dir_n;
            end
        end
    end
endmodule

// File: tb/tb_people_top_control.sv
// tb_people_top_control: directed and randomized checks of people_top_control against a cycle-level reference model.
module tb_people_top_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] stage_state = 3'd0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic fail = 1'b0;
    logic [9:0] people_up, people_left;
    logic [1:0] people_dir, state;
    logic win;

    int checks = 0;
    int errors = 0;
    int m_st = 0, m_up = 335, m_left = 160, m_dir = 0, m_cnt = 0, m_tick = 0;

    people_top_control #(.TICK_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .stage_state(stage_state),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .fail(fail), .people_up(people_up), .people_left(people_left),
        .people_dir(people_dir), .win(win), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    // One clock: the model derives the next values from the rules, then every output is compared.
    task automatic step();
        int n_st, n_up, n_left, n_dir, n_cnt, n_tick, dy, dx;
        bit act;
        act = stage_state == 3'd5;
        n_st = m_st; n_up = m_up; n_left = m_left; n_dir = m_dir;
        n_cnt = 0; n_tick = 0;
        if (rst) begin
            n_st = 0; n_up = 335; n_left = 160; n_dir = 0;
        end else begin
            if (m_st == 0) n_st = (act && !fail) ? 1 : 0;
            else if (m_st == 1) n_st = !act ? 0 : fail ? 2 : (m_left >= 430) ? 3 : 1;
            else if (!act) n_st = 0;
            if (m_st == 1) begin
                n_tick = (m_cnt == 3);
                n_cnt = (m_cnt + 1) % 4;
            end
            dy = int'(key_down) - int'(key_up);
            dx = int'(key_right) - int'(key_left);
            if (m_st == 0) begin
                n_up = 335; n_left = 160; n_dir = 0;
            end else if (m_st == 1 && m_tick == 1) begin
                if (dy != 0) begin
                    n_dir = dy < 0 ? 2 : 3;
                    n_up = clamp(m_up + dy, 40, 400);
                end else if (dx != 0) begin
                    n_dir = dx > 0 ? 0 : 1;
                    n_left = clamp(m_left + dx, 160, 440);
                end
            end
        end
        @(posedge clk);
        #1;
        m_st = n_st; m_up = n_up; m_left = n_left; m_dir = n_dir; m_cnt = n_cnt; m_tick = n_tick;
        chk("state", int'(state), m_st);
        chk("people_up", int'(people_up), m_up);
        chk("people_left", int'(people_left), m_left);
        chk("people_dir", int'(people_dir), m_dir);
        chk("win", int'(win), m_st == 3 ? 1 : 0);
    endtask

    task automatic keys(input logic [3:0] k);
        {key_up, key_down, key_left, key_right} = k;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2);
        stage_state = 3'd5;
        keys(4'b0001);
        run(24);
        chk("first_moves_left", int'(people_left), 165);
        keys(4'b1010);
        run(12);
        keys(4'b0010);
        run(300);
        chk("clamp_left", int'(people_left), 160);
        chk("clamp_left_dir", int'(people_dir), 1);
        keys(4'b1000);
        run(1300);
        chk("clamp_up", int'(people_up), 40);
        keys(4'b1100);
        run(20);
        keys(4'b0100);
        run(1500);
        chk("clamp_down", int'(people_up), 400);
        keys(4'b0001);
        run(1200);
        chk("win_state", int'(state), 3);
        chk("win_left", int'(people_left), 430);
        fail = 1'b1;
        run(10);
        fail = 1'b0;
        stage_state = 3'd4;
        run(3);
        chk("idle_reload_up", int'(people_up), 335);
        stage_state = 3'd5;
        keys(4'b0001);
        run(170);
        fail = 1'b1;
        keys(4'b1000);
        run(40);
        chk("dead_state", int'(state), 2);
        stage_state = 3'd0;
        run(3);
        stage_state = 3'd5;
        run(6);
        chk("fail_blocks_play", int'(state), 0);
        fail = 1'b0;
        reset_pulse();
        keys(4'b0001);
        for (int i = 0; i < 2000 && m_left < 430; i++) step();
        fail = 1'b1;
        step();
        chk("fail_beats_goal", int'(state), 2);
        run(8);
        fail = 1'b0;
        reset_pulse();
        keys(4'b1000);
        run(145);
        keys(4'b0001);
        run(360);
        reset_pulse();
        chk("rst_mid_play_state", int'(state), 0);
        run(30);
        for (int s = 0; s < 80; s++) begin
            keys(4'($urandom));
            stage_state = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd5;
            fail = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 19) == 0) reset_pulse();
            run($urandom_range(3, 60));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/people_top_control.md
Name: people_top_control

Overview:
- Player-sprite position controller for the maze stage; the producer of the people_up/people_left coordinates that the ghost patrol controllers consume, and the consumer of their sticky fail flags.
- Moves the 40x40 player sprite from debounced direction-key levels at a fixed pixel rate and clamps it to the playfield.
- Freezes the sprite on death, raises win when the goal column is reached, and reloads the start position whenever the stage is not active.

Parameters:
- TICK_CYCLES, 1_000_000: clk cycles per movement step (1 px per step).
- ACTIVE_STAGE, 5: stage_state value in which the player may move.
- START_UP, 335: start/reload vertical coordinate (top edge of sprite).
- START_LEFT, 160: start/reload horizontal coordinate (left edge of sprite).
- MIN_UP / MAX_UP, 40 / 400: inclusive clamp range for people_up.
- MIN_LEFT / MAX_LEFT, 160 / 440: inclusive clamp range for people_left.
- GOAL_LEFT, 430: people_left >= GOAL_LEFT in PLAY means goal reached.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- stage_state, input, 3: current game stage.
- key_up, key_down, key_left, key_right, input, 1 each: debounced key levels, 1 = held.
- fail, input, 1: OR of the ghost fail flags (sticky until rst).
- people_up, output, 10: sprite top coordinate.
- people_left, output, 10: sprite left coordinate.
- people_dir, output, 2: facing direction (0 right, 1 left, 2 up, 3 down), used for sprite selection.
- win, output, 1: goal reached, sticky until the FSM leaves WIN.
- state, output, 2: FSM state (0 IDLE, 1 PLAY, 2 DEAD, 3 WIN).

Behaviour:
- Reset values: people_up=START_UP, people_left=START_LEFT, people_dir=0, win=0, state=IDLE, tick counter=0, tick=0.
- IDLE:
  - Position is forced to START_UP/START_LEFT every cycle; people_dir=0; win=0; counter held at 0.
  - Goes to PLAY on the cycle after stage_state==ACTIVE_STAGE is sampled with fail==0.
  - If fail==1 at that point, stays in IDLE.
- Tick generator:
  - Counts only in PLAY.
  - When count==TICK_CYCLES-1: count goes to 0 and the registered tick goes to 1 for one cycle; otherwise tick=0.
  - In any other state, count=0 and tick=0.
  - The first tick is asserted TICK_CYCLES cycles after PLAY is entered.
- Movement (PLAY only, on the edge where tick==1):
  - Moves exactly one axis by 1 px, chosen by priority up > down > left > right among the held keys.
  - Opposing keys both held (up+down, or left+right): that axis is ignored and priority continues to the other axis.
  - No key held: no move, people_dir unchanged.
  - Clamp: a step that would go past MIN/MAX is suppressed, but people_dir still updates to the pressed direction.
  - Only tick-qualified samples matter; keys between ticks are ignored.
  - New position is visible on the cycle after the tick.
- Transitions out of PLAY, evaluated every cycle in this order:
  - stage_state!=ACTIVE_STAGE -> IDLE (position reloaded next cycle).
  - Else fail==1 -> DEAD.
  - Else people_left>=GOAL_LEFT -> WIN.
  - Fail and goal in the same cycle: DEAD wins.
- DEAD: position and people_dir frozen, win=0; leaves only when stage_state!=ACTIVE_STAGE (-> IDLE) or on rst.
- WIN: win=1, position frozen; stage_state!=ACTIVE_STAGE -> IDLE with win=0 the following cycle; fail asserting while in WIN is ignored.
- Arithmetic: 10-bit unsigned. Clamp compares are performed before the +/-1, so wrap-around never occurs.
- rst in any state: all outputs return to reset values on the next edge; an in-flight tick is discarded.

Test Plan (TICK_CYCLES=4 in sim):
- Reset, then stage_state=5 with key_right held: state=PLAY 1 cycle later; people_left 160->161 on the cycle after the first tick (4 cycles into PLAY), then +1 every 4 cycles; people_dir=0.
- key_up and key_left both held from (335,160): only people_up decrements (335->334->333); people_left stays 160; people_dir=2.
- Clamp: key_left held at people_left=160 -> people_left stays 160 over 10 ticks, people_dir=1. key_up held from people_up=41 -> 40, then stays 40.
- Drive right to 430 -> state=WIN and win=1 the next cycle; further ticks leave 430 unchanged. Set stage_state=4 -> IDLE, win=0, position=(335,160).
- fail=1 while at (335,200) -> DEAD, position frozen while keys are held. Fail and people_left reaching 430 in the same cycle -> DEAD, win stays 0.
- rst pulsed mid-PLAY at (300,250) -> (335,160), people_dir=0, state=IDLE, counter=0; then re-entering PLAY gives the first move exactly 4 cycles later.
